mult_ctrl: RTL
==============

Name: mult_ctrl

Overview:
Control FSM for the 4-bit shift-add sequential multiplier datapath. It sequences load, test, add and shift of the multiplicand (a), multiplier (b) and partial-product (p) registers by driving their enables and mux selects. It consumes the datapath's registered `zero` and `lsb_b` flags and exposes a start/busy/done handshake to the host.

Parameters:
- WIDTH, 4: multiplier operand width; also the maximum number of shift iterations.
- CNT_W, 3: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- start  in  1  request a multiply; sampled only in IDLE.
- zero  in  1  datapath flag, registered: b == 0 as of previous edge.
- lsb_b  in  1  datapath flag, registered: b[0] as of previous edge.
- en_a  out  1  a register enable.
- ld_shift_a  out  1  a mux select: 0 = load a_in, 1 = shift.
- en_b  out  1  b register enable.
- ld_shift_b  out  1  b mux select: 0 = load b_in, 1 = shift.
- en_p  out  1  p register enable.
- ld_add_p  out  1  p mux select: 0 = clear to 0, 1 = a + p.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  one-cycle pulse; p_out is valid in the datapath.
- overrun  out  1  sticky; iteration guard tripped; cleared on the next accepted start.
- iter  out  CNT_W  shift iterations completed in the current operation.

Behaviour:
- Reset (clr = 0, async):
  - state = IDLE.
  - All outputs 0, including iter and overrun.
  - Reset mid-operation abandons the operation; no done pulse is issued.
- All outputs are Moore, decoded from state (overrun and iter are registers).
- Any enable or select not listed for a state is 0.
- IDLE:
  - No enables; busy = 0.
  - start = 1 → LOAD.
  - Clear iter and overrun on this transition.
- LOAD:
  - en_a = en_b = en_p = 1; ld_shift_a = ld_shift_b = ld_add_p = 0.
  - Operands load and p clears.
  - → SYNC.
- SYNC:
  - No enables.
  - Exists because the flags lag b by one edge; it lets zero/lsb_b reflect the current b.
  - → TEST.
- TEST: no enables. Transitions evaluated in priority order:
  - zero = 1 → DONE.
  - else iter == WIDTH → set overrun, → DONE.
  - else lsb_b = 1 → ADD.
  - else → SHIFT.
- ADD:
  - en_p = 1, ld_add_p = 1; p <= a + p.
  - → SHIFT.
- SHIFT:
  - en_a = en_b = 1, ld_shift_a = ld_shift_b = 1.
  - iter <= iter + 1.
  - → SYNC.
- DONE:
  - done = 1 for exactly one cycle.
  - → IDLE.
  - start is ignored in DONE; a new start is accepted in the following IDLE cycle at the earliest.
- start is ignored whenever busy = 1; holding start high causes back-to-back operations separated by one IDLE cycle.
- Latency, counting the cycle after the edge that samples start as cycle 1:
  - done occurs in cycle 4 + 3·S + A.
  - S = shifts performed (position of the highest set bit of b, counted from 1).
  - A = number of 1 bits in b.
- iter never exceeds WIDTH; it holds its value after DONE until the next accepted start.
- Unused state encodings recover to IDLE on the next edge with all outputs 0.

Test Plan:
- Reset, then a = 3, b = 5 (0101), start pulse → states LOAD, SYNC, TEST, ADD, SHIFT, SYNC, TEST, SHIFT, SYNC, TEST, ADD, SHIFT, SYNC, TEST, DONE; done in cycle 15; iter = 3; overrun = 0; datapath p_out = 15.
- b = 0, a = 9, start → LOAD, SYNC, TEST, DONE; done in cycle 4; iter = 0; en_p asserted only in LOAD.
- b = 15, a = 15 → four ADD/SHIFT pairs; done in cycle 20; iter = 4; p_out = 225 (with 8-bit p).
- start held high continuously with b = 1 → done in cycle 8; one IDLE cycle; next LOAD the cycle after; busy low only in that IDLE cycle.
- Drive clr low during the second ADD of b = 5 → all outputs 0 immediately with no clock edge; no done pulse; a fresh start runs a full operation correctly.
- Force zero = 0 and lsb_b = 0 permanently → after 4 SHIFTs, TEST sets overrun = 1 and emits done; overrun stays 1 through IDLE and clears on the next start.

Source files
------------

// File: rtl/mult_ctrl.sv
// mult_ctrl: control FSM for a shift-add sequential multiplier datapath.
// Sequences load / test / add / shift of the a, b and p registers and
// provides a start/busy/done handshake. Outputs are Moore; iter and
// overrun are registered.
module mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             zero,
    input  logic             lsb_b,
    output logic             en_a,
    output logic             ld_shift_a,
    output logic             en_b,
    output logic             ld_shift_b,
    output logic             en_p,
    output logic             ld_add_p,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SYNC  = 3'd2,
        TEST  = 3'd3,
        ADD   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic iter_at_max;
    assign iter_at_max = (iter == CNT_W'(WIDTH));

    // State register; clr abandons any operation in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and Moore output decode; unused encodings fall to IDLE.
    always_comb begin
        state_nxt  = IDLE;
        en_a       = 1'b0;
        ld_shift_a = 1'b0;
        en_b       = 1'b0;
        ld_shift_b = 1'b0;
        en_p       = 1'b0;
        ld_add_p   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = start ? LOAD : IDLE;
            end
            LOAD: begin
                en_a      = 1'b1;
                en_b      = 1'b1;
                en_p      = 1'b1;
                busy      = 1'b1;
                state_nxt = SYNC;
            end
            SYNC: begin
                busy      = 1'b1;
                state_nxt = TEST;
            end
            TEST: begin
                busy = 1'b1;
                if (zero)             state_nxt = DONE;
                else if (iter_at_max) state_nxt = DONE;
                else if (lsb_b)       state_nxt = ADD;
                else                  state_nxt = SHIFT;
            end
            ADD: begin
                en_p      = 1'b1;
                ld_add_p  = 1'b1;
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                en_a       = 1'b1;
                ld_shift_a = 1'b1;
                en_b       = 1'b1;
                ld_shift_b = 1'b1;
                busy       = 1'b1;
                state_nxt  = SYNC;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter and sticky overrun flag; both clear on an accepted start.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            iter    <= '0;
            overrun <= 1'b0;
        end else if (state == IDLE && start) begin
            iter    <= '0;
            overrun <= 1'b0;
        end else if (state == SHIFT) begin
            iter <= iter + CNT_W'(1);
        end else if (state == TEST && !zero && iter_at_max) begin
            overrun <= 1'b1;
        end
    end

endmodule
